// File: rtl/queue_ctrl_4x4b_if.sv
// queue_ctrl_4x4b_if: handshake and register-file signals of the 4x4b queue control stage
//   enq_val/enq_rdy/enq_data : producer handshake and payload
//   deq_val/deq_rdy/deq_data : consumer handshake and payload
//   rf_wen/rf_waddr/rf_wdata : register file write port
//   rf_raddr/rf_rdata        : register file read port (combinational read)
//   count                    : occupancy 0..4
//   master = queue controller side, slave = producer/consumer/register file side
interface queue_ctrl_4x4b_if;
    logic       enq_val;
    logic       enq_rdy;
    logic [3:0] enq_data;
    logic       deq_val;
    logic       deq_rdy;
    logic [3:0] deq_data;
    logic       rf_wen;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic [1:0] rf_raddr;
    logic [3:0] rf_rdata;
    logic [2:0] count;
    modport master (
        input  enq_val, enq_data, deq_rdy, rf_rdata,
        output enq_rdy, deq_val, deq_data, rf_wen, rf_waddr, rf_wdata, rf_raddr, count
    );
    modport slave (
        output enq_val, enq_data, deq_rdy, rf_rdata,
        input  enq_rdy, deq_val, deq_data, rf_wen, rf_waddr, rf_wdata, rf_raddr, count
    );
endinterface

// File: rtl/queue_ctrl_4x4b.sv
// queue_ctrl_4x4b: pointer/occupancy control for a 4-entry 4-bit FIFO over an external register file
//   clk, rst : clock and synchronous active-high reset
//   q        : queue_ctrl_4x4b_if.master (enq/deq handshakes, register file ports, count)
//   QUEUE_CTRL_4X4B_BYPASS_EN : when defined, an empty queue passes enq_data straight to deq_data
module queue_ctrl_4x4b (
    input logic             clk,
    input logic             rst,
    queue_ctrl_4x4b_if.master q
);
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] cnt;
    logic       byp;
    logic       enq_fire;
    logic       deq_fire;
`ifdef QUEUE_CTRL_4X4B_BYPASS_EN
    assign byp = !rst && cnt == 3'd0 && q.enq_val && q.deq_rdy;
`else
    assign byp = 1'b0;
`endif
    assign q.enq_rdy  = !rst && cnt != 3'd4;
    assign q.deq_val  = (!rst && cnt != 3'd0) || byp;
    assign q.deq_data = byp ? q.enq_data : q.rf_rdata;
    // a bypassed transfer touches neither the register file nor any state
    assign enq_fire   = q.enq_val && q.enq_rdy && !byp;
    assign deq_fire   = q.deq_val && q.deq_rdy && !byp;
    assign q.rf_wen   = enq_fire;
    assign q.rf_waddr = wptr;
    assign q.rf_wdata = q.enq_data;
    assign q.rf_raddr = rptr;
    assign q.count    = cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= 2'd0;
            rptr <= 2'd0;
            cnt  <= 3'd0;
        end else begin
            wptr <= wptr + {1'b0, enq_fire};
            rptr <= rptr + {1'b0, deq_fire};
            cnt  <= cnt + {2'b0, enq_fire} - {2'b0, deq_fire};
        end
    end
endmodule

// File: tb/tb_queue_ctrl_4x4b.sv
// tb_queue_ctrl_4x4b: directed self-checking bench for queue_ctrl_4x4b with a behavioural 4x4b register file
module tb_queue_ctrl_4x4b;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] mem [4];
    always #5 clk = ~clk;
    queue_ctrl_4x4b_if q ();
    queue_ctrl_4x4b dut (.clk(clk), .rst(rst), .q(q));
    assign q.rf_rdata = mem[q.rf_raddr];
    always @(posedge clk) if (q.rf_wen) mem[q.rf_waddr] <= q.rf_wdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; q.enq_val = 1'b1; q.enq_data = 4'hF; q.deq_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (q.enq_rdy !== 1'b0) begin errors++; $display("FAIL reset_enq_rdy got %b exp 0", q.enq_rdy); end
            checks++; if (q.deq_val !== 1'b0) begin errors++; $display("FAIL reset_deq_val got %b exp 0", q.deq_val); end
            checks++; if (q.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %b exp 0", q.rf_wen); end
            tick();
        end
        rst = 1'b0; q.enq_val = 1'b0;
        #1;
        checks++; if (q.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", q.count); end
        checks++; if (q.enq_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_enq_rdy got %b exp 1", q.enq_rdy); end
        checks++; if (q.deq_val !== 1'b0) begin errors++; $display("FAIL reset_release_deq_val got %b exp 0", q.deq_val); end
    endtask

    task automatic test_fill;
        q.enq_val = 1'b1; q.deq_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q.enq_data = 4'(i + 1);
            #1;
            checks++; if (q.rf_wen !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d] got %b exp 1", i, q.rf_wen); end
            checks++; if (q.rf_waddr !== 2'(i)) begin errors++; $display("FAIL fill_waddr[%0d] got %0d exp %0d", i, q.rf_waddr, i); end
            checks++; if (q.rf_wdata !== 4'(i + 1)) begin errors++; $display("FAIL fill_wdata[%0d] got %h exp %h", i, q.rf_wdata, i + 1); end
            tick();
        end
        q.enq_data = 4'h5;
        #1;
        checks++; if (q.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", q.count); end
        checks++; if (q.enq_rdy !== 1'b0) begin errors++; $display("FAIL full_enq_rdy got %b exp 0", q.enq_rdy); end
        checks++; if (q.rf_wen !== 1'b0) begin errors++; $display("FAIL full_rf_wen got %b exp 0", q.rf_wen); end
        tick();
        checks++; if (q.count !== 3'd4) begin errors++; $display("FAIL full_hold_count got %0d exp 4", q.count); end
        q.enq_val = 1'b0;
    endtask

    task automatic test_drain;
        q.deq_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (q.deq_val !== 1'b1) begin errors++; $display("FAIL drain_val[%0d] got %b exp 1", i, q.deq_val); end
            checks++; if (q.deq_data !== 4'(i + 1)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, q.deq_data, i + 1); end
            tick();
        end
        checks++; if (q.deq_val !== 1'b0) begin errors++; $display("FAIL empty_deq_val got %b exp 0", q.deq_val); end
        checks++; if (q.count !== 3'd0) begin errors++; $display("FAIL empty_count got %0d exp 0", q.count); end
        q.deq_rdy = 1'b0;
    endtask

    task automatic test_wrap;
        logic [1:0] exp_waddr [6];
        exp_waddr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 7; i++) begin
            q.enq_val  = (i < 6);
            q.enq_data = 4'(10 + i);
            q.deq_rdy  = (i > 0);
            #1;
            if (i < 6) begin
                checks++; if (q.rf_waddr !== exp_waddr[i] || q.rf_wen !== 1'b1) begin errors++; $display("FAIL wrap_waddr[%0d] got %0d/%b exp %0d/1", i, q.rf_waddr, q.rf_wen, exp_waddr[i]); end
            end
            if (i > 0) begin
                checks++; if (q.deq_val !== 1'b1 || q.deq_data !== 4'(9 + i)) begin errors++; $display("FAIL wrap_deq[%0d] got %b/%h exp 1/%h", i, q.deq_val, q.deq_data, 9 + i); end
            end
            tick();
        end
        q.enq_val = 1'b0; q.deq_rdy = 1'b0;
        checks++; if (q.count !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", q.count); end
    endtask

    task automatic test_simultaneous;
        q.enq_val = 1'b1; q.deq_rdy = 1'b0;
        q.enq_data = 4'h3; tick();
        q.enq_data = 4'h6; tick();
        checks++; if (q.count !== 3'd2) begin errors++; $display("FAIL simul_pre_count got %0d exp 2", q.count); end
        q.enq_data = 4'h9; q.deq_rdy = 1'b1;
        #1;
        checks++; if (q.deq_data !== 4'h3) begin errors++; $display("FAIL simul_head got %h exp 3", q.deq_data); end
        checks++; if (q.rf_wen !== 1'b1 || q.rf_waddr !== 2'd0) begin errors++; $display("FAIL simul_write got %b/%0d exp 1/0", q.rf_wen, q.rf_waddr); end
        checks++; if (q.rf_raddr !== 2'd2) begin errors++; $display("FAIL simul_raddr got %0d exp 2", q.rf_raddr); end
        tick();
        q.enq_val = 1'b0;
        #1;
        checks++; if (q.count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d exp 2", q.count); end
        checks++; if (q.rf_raddr !== 2'd3 || q.rf_waddr !== 2'd1) begin errors++; $display("FAIL simul_ptrs got r%0d/w%0d exp r3/w1", q.rf_raddr, q.rf_waddr); end
        checks++; if (q.deq_data !== 4'h6) begin errors++; $display("FAIL simul_order0 got %h exp 6", q.deq_data); end
        tick();
        checks++; if (q.deq_val !== 1'b1 || q.deq_data !== 4'h9) begin errors++; $display("FAIL simul_order1 got %b/%h exp 1/9", q.deq_val, q.deq_data); end
        tick();
        checks++; if (q.count !== 3'd0 || q.deq_val !== 1'b0) begin errors++; $display("FAIL simul_drained got %0d/%b exp 0/0", q.count, q.deq_val); end
        q.deq_rdy = 1'b0;
    endtask

    task automatic test_bypass;
        q.enq_val = 1'b1; q.enq_data = 4'h7; q.deq_rdy = 1'b1;
        #1;
`ifdef QUEUE_CTRL_4X4B_BYPASS_EN
        checks++; if (q.deq_val !== 1'b1 || q.deq_data !== 4'h7) begin errors++; $display("FAIL bypass_deq got %b/%h exp 1/7", q.deq_val, q.deq_data); end
        checks++; if (q.rf_wen !== 1'b0) begin errors++; $display("FAIL bypass_rf_wen got %b exp 0", q.rf_wen); end
        tick();
        q.enq_val = 1'b0;
        #1;
        checks++; if (q.count !== 3'd0 || q.deq_val !== 1'b0) begin errors++; $display("FAIL bypass_after got %0d/%b exp 0/0", q.count, q.deq_val); end
`else
        checks++; if (q.deq_val !== 1'b0) begin errors++; $display("FAIL nobypass_deq_val got %b exp 0", q.deq_val); end
        checks++; if (q.rf_wen !== 1'b1) begin errors++; $display("FAIL nobypass_rf_wen got %b exp 1", q.rf_wen); end
        tick();
        q.enq_val = 1'b0;
        #1;
        checks++; if (q.deq_val !== 1'b1 || q.deq_data !== 4'h7) begin errors++; $display("FAIL nobypass_next got %b/%h exp 1/7", q.deq_val, q.deq_data); end
        tick();
        checks++; if (q.count !== 3'd0) begin errors++; $display("FAIL nobypass_count got %0d exp 0", q.count); end
`endif
        q.deq_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/queue_ctrl_4x4b.md
# queue_ctrl_4x4b

Control stage for a 4-entry, 4-bit FIFO queue built on an external flat 4x4b register file with one write port and one read port. The block sits directly in front of the register file. It turns val/rdy enqueue and dequeue handshakes into the register file's write-enable, write-address, write-data and read-address inputs. It returns the register file's combinational read data as the dequeue payload. It owns all pointer, occupancy and flow-control state; the register file holds only the data.

## Interface

Parameters:
- None. Geometry is fixed at 4 entries x 4 bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- enq_val  input  1  producer has valid data on enq_data.
- enq_rdy  output  1  queue can accept an enqueue this cycle.
- enq_data  input  4  enqueue payload.
- deq_val  output  1  deq_data holds a valid head entry.
- deq_rdy  input  1  consumer accepts the head this cycle.
- deq_data  output  4  dequeue payload.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  2  register file write address.
- rf_wdata  output  4  register file write data.
- rf_raddr  output  2  register file read address.
- rf_rdata  input  4  register file read data, combinational from rf_raddr.
- count  output  3  current occupancy, 0..4.

## Operation

- State registers:
  - wptr[1:0]: next slot to write.
  - rptr[1:0]: head slot.
  - cnt[2:0]: occupancy.
- Reset: while rst=1, enq_rdy=0, deq_val=0 and rf_wen=0. At the posedge with rst=1, wptr, rptr and cnt are cleared to 0. rst overrides any handshake in the same cycle, and any in-flight contents are discarded.
- Flow control:
  - enq_rdy = !rst and (cnt != 4).
  - deq_val = !rst and (cnt != 0).
  - Full is cnt==4. Empty is cnt==0.
- Transfers:
  - enq fire = enq_val and enq_rdy.
  - deq fire = deq_val and deq_rdy.
- Register file drive:
  - rf_wen = enq fire.
  - rf_waddr = wptr.
  - rf_wdata = enq_data.
  - rf_raddr = rptr.
  - deq_data = rf_rdata.
- Updates:
  - On enq fire, wptr increments by 1 modulo 4 (3 wraps to 0).
  - On deq fire, rptr increments by 1 modulo 4.
  - Enq only: cnt+1. Deq only: cnt-1. Both fire: cnt unchanged.
- When full, enq_rdy=0 even if deq_rdy=1. Ready does not depend combinationally on deq_rdy.
- Simultaneous enq and deq with 0<cnt<4: both pointers advance, the write lands in the tail slot, and the read is taken from the head slot.
- count = cnt.
- deq_data is don't-care when deq_val=0.

## Timing

- Enqueue-to-dequeue latency: 1 cycle. Data written at posedge N is visible on deq_data with deq_val=1 in cycle N+1.
- enq_rdy and deq_val are functions of registered state only (plus rst). This holds except on the bypass path under the configuration macro.
- The register file write occurs at the same posedge as the pointer update.
- Throughput: one enqueue and one dequeue per cycle, sustained, while 0<cnt<4.
- Reset takes effect at the first posedge with rst=1. The first enqueue is possible in the cycle after rst falls.

## Configuration

- QUEUE_CTRL_4X4B_BYPASS_EN
  - Defined: when cnt==0, enq_val=1 and deq_rdy=1, the entry passes straight through.
    - deq_val=1 and deq_data=enq_data combinationally in the same cycle.
    - rf_wen=0.
    - Pointers and cnt are unchanged.
    - Enqueue latency to an empty queue is 0 cycles.
  - Undefined: no bypass. An empty queue always shows deq_val=0, and the latency is 1 cycle.

## Test plan

- Reset: assert rst for 2 cycles, with enq_val=1 driven during reset -> enq_rdy=0, deq_val=0, rf_wen=0 during reset; after release, count=0 and enq_rdy=1.
- Fill/full: enqueue 0x1, 0x2, 0x3, 0x4 with deq_rdy=0 -> rf_waddr steps 0,1,2,3, count reaches 4, then enq_rdy=0; a fifth enq_val=1 with 0x5 causes no write.
- Drain/empty: from full, hold deq_rdy=1 -> deq_data sequence 0x1, 0x2, 0x3, 0x4, then deq_val=0 and count=0.
- Wrap-around: run 6 enqueues interleaved with dequeues -> wptr wraps from 3 to 0, and data order is preserved (0xA..0xF out in order).
- Simultaneous: with count=2, fire enq (0x9) and deq in the same cycle -> count stays 2, both pointers advance, and 0x9 appears after the two older entries.
- Bypass: with the macro defined and count=0, enq_val=1 with 0x7 and deq_rdy=1 -> same-cycle deq_val=1, deq_data=0x7, rf_wen=0, count stays 0. With the macro undefined -> deq_val=0 that cycle, and 0x7 appears in the next cycle.
